// File: rtl/decoder_38.sv
// decoder_38: registered 1-to-8 data demultiplexer steering data_in to the port chosen by sel
module decoder_38 #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [DATA_W-1:0] data_out_3,
  output logic [DATA_W-1:0] data_out_4,
  output logic [DATA_W-1:0] data_out_5,
  output logic [DATA_W-1:0] data_out_6,
  output logic [DATA_W-1:0] data_out_7
);
  logic [7:0][DATA_W-1:0] data_q, data_d;
  // route data to the selected slot only; every other slot is forced to zero
  always_comb begin
    data_d = '0;
    if (en) data_d[sel] = data_in;
  end
  // register the steered data; async clear of all outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else data_q <= data_d;
  end
  assign data_out_0 = data_q[0];
  assign data_out_1 = data_q[1];
  assign data_out_2 = data_q[2];
  assign data_out_3 = data_q[3];
  assign data_out_4 = data_q[4];
  assign data_out_5 = data_q[5];
  assign data_out_6 = data_q[6];
  assign data_out_7 = data_q[7];
endmodule

// File: tb/tb_decoder_38.sv
// tb_decoder_38: directed self-checking bench for decoder_38
module tb_decoder_38;
  logic       clk, rst_n, en;
  logic [2:0] sel;
  logic [3:0] data_in;
  logic [3:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [31:0] outs;
  int n_chk, n_pass;
  logic [31:0] sweep_exp [8];

  decoder_38 #(.DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .data_in(data_in), .en(en),
    .data_out_0(o0), .data_out_1(o1), .data_out_2(o2), .data_out_3(o3),
    .data_out_4(o4), .data_out_5(o5), .data_out_6(o6), .data_out_7(o7)
  );

  assign outs = {o7, o6, o5, o4, o3, o2, o1, o0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input logic e, input logic [2:0] s, input logic [3:0] d);
    en = e;
    sel = s;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    sweep_exp = '{32'h0000_000F, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_F000,
                  32'h000F_0000, 32'h00F0_0000, 32'h0F00_0000, 32'hF000_0000};
    rst_n = 1'b0;
    en = 1'b1;
    sel = 3'd5;
    data_in = 4'hA;
    #1 check("reset_init", outs, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 3'd5, 4'hA);
    check("load_sel5", outs, 32'h00A0_0000);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs, 32'h0);
    @(posedge clk);
    #1 check("reset_held", outs, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 3'd5, 4'hA);
    check("post_reset", outs, 32'h00A0_0000);
    cyc(1'b1, 3'd0, 4'h0);
    check("sel0_zero_data", outs, 32'h0);
    cyc(1'b0, 3'd0, 4'h1);
    check("en_off_data", outs, 32'h0);
    cyc(1'b1, 3'd0, 4'h1);
    check("en_on_sel0", outs, 32'h0000_0001);
    cyc(1'b0, 3'd1, 4'h1);
    check("en_off_sel", outs, 32'h0);
    cyc(1'b1, 3'd1, 4'h1);
    check("en_on_sel1", outs, 32'h0000_0010);
    cyc(1'b1, 3'd1, 4'h2);
    check("xfer_2", outs, 32'h0000_0020);
    cyc(1'b1, 3'd1, 4'h3);
    check("xfer_3", outs, 32'h0000_0030);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'(i), 4'hF);
      check($sformatf("sweep_%0d", i), outs, sweep_exp[i]);
    end
    cyc(1'b1, 3'd2, 4'h3);
    check("simul_pre", outs, 32'h0000_0300);
    en = 1'b1;
    sel = 3'd3;
    data_in = 4'h9;
    #1 check("no_comb_path", outs, 32'h0000_0300);
    @(posedge clk);
    @(negedge clk);
    check("simul_post", outs, 32'h0000_9000);
    cyc(1'b0, 3'd7, 4'hF);
    check("en_off_final", outs, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
